// File: rtl/data_mem_pkg.sv
// Shared constants and types for the 4 KiB byte-addressable data memory.
package data_mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic MEMOP_BYTE = 1'b0;
  localparam logic MEMOP_WORD = 1'b1;

  typedef logic [1:0] lane_t;
endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: picks the addressed byte for byte loads and extends it.
// Byte loads are sign-extended when DMEM_BYTE_SEXT_EN is defined, zero-extended otherwise.
import data_mem_pkg::*;

module dmem_load_align (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        MemOp,
  output logic [31:0] data
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = word[7:0];
    case (lane)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
  end

  always_comb begin
    data = word;
    if (MemOp == MEMOP_BYTE) begin
`ifdef DMEM_BYTE_SEXT_EN
      data = {{24{sel_byte[7]}}, sel_byte};
`else
      data = {24'h0, sel_byte};
`endif
    end
  end

endmodule

// File: rtl/data_mem.sv
// 4 KiB little-endian data memory: synchronous writes, combinational reads.
// Optional build macro DMEM_BYTE_SEXT_EN (sign-extended byte loads) is handled in dmem_load_align.
import data_mem_pkg::*;

module data_mem #(
  parameter int ADDR_W = data_mem_pkg::ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              MemOp,
  input  logic              MemWr,
  output logic [DATA_W-1:0] DataOut
);

  localparam int MEM_DEPTH = 1 << ADDR_W;

  logic [7:0] mem [MEM_DEPTH];

  // No handshake: every cycle carries a request; MemWr alone qualifies a store.
  lane_t             lane;
  logic [ADDR_W-3:0] word_idx;
  logic [3:0]        lane_en;
  logic [7:0]        lane_data [4];
  logic [31:0]       rd_word;
  logic [31:0]       load_data;

  assign lane     = Addr[1:0];
  assign word_idx = Addr[ADDR_W-1:2];

  always_comb begin
    lane_en = 4'h0;
    for (int k = 0; k < 4; k++) begin
      lane_data[k] = DataIn[7:0];
    end
    if (MemOp == MEMOP_WORD) begin
      lane_en = 4'hF;
      for (int k = 0; k < 4; k++) begin
        lane_data[k] = DataIn[8*k +: 8];
      end
    end else begin
      lane_en[lane] = 1'b1;
    end
  end

  // Reset wins over a store requested in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (MemWr) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          mem[{word_idx, 2'(k)}] <= lane_data[k];
        end
      end
    end
  end

  assign rd_word = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                    mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};

  dmem_load_align u_align (
    .word  (rd_word),
    .lane  (lane),
    .MemOp (MemOp),
    .data  (load_data)
  );

  assign DataOut = rst ? '0 : load_data;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed load/store cases plus a random byte-store region.
module tb_data_mem;

  logic        clk;
  logic        rst;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic        MemOp;
  logic        MemWr;
  logic [31:0] DataOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  model [4096];

  data_mem dut (
    .clk     (clk),
    .rst     (rst),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .MemOp   (MemOp),
    .MemWr   (MemWr),
    .DataOut (DataOut)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bext(input logic [7:0] b);
`ifdef DMEM_BYTE_SEXT_EN
    return {{24{b[7]}}, b};
`else
    return {24'h0, b};
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic op);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    if (op) return {model[b + 12'd3], model[b + 12'd2], model[b + 12'd1], model[b]};
    return bext(model[a]);
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic op);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    if (op) begin
      model[b]         = d[7:0];
      model[b + 12'd1] = d[15:8];
      model[b + 12'd2] = d[23:16];
      model[b + 12'd3] = d[31:24];
    end else begin
      model[a] = d[7:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one store cycle
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic op);
    Addr = a; DataIn = d; MemOp = op; MemWr = 1'b1;
    tick();
    MemWr = 1'b0;
    model_write(a, d, op);
  endtask

  // driver: combinational read, expected value queued then compared
  task automatic rd(input string tag, input logic [11:0] a, input logic op, input logic [31:0] exp);
    Addr = a; MemOp = op; MemWr = 1'b0;
    exp_q.push_back(exp);
    #1;
    check(tag, DataOut, exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model[i] = 8'h00;
    rst = 1'b1; Addr = 12'h000; DataIn = 32'hFFFF_FFFF; MemOp = 1'b1; MemWr = 1'b1;
    #1;
    check("out_in_reset", DataOut, 32'h0);
    tick();
    rst = 1'b0; MemWr = 1'b0;
    rd("reset_rd0", 12'h000, 1'b1, 32'h0);

    wr(12'h000, 32'hDEADBEEF, 1'b1);
    wr(12'h004, 32'h12345678, 1'b1);
    rd("word_rd0", 12'h000, 1'b1, 32'hDEADBEEF);
    rd("word_rd4", 12'h004, 1'b1, 32'h12345678);
    rd("byte_rd0", 12'h000, 1'b0, bext(8'hEF));
    rd("byte_rd3", 12'h003, 1'b0, bext(8'hDE));
    rd("byte_rd5", 12'h005, 1'b0, 32'h00000056);

    wr(12'h001, 32'hAAAAAA11, 1'b0);
    rd("bwr_word0", 12'h000, 1'b1, 32'hDEAD11EF);
    rd("bwr_word4", 12'h004, 1'b1, 32'h12345678);

    wr(12'h006, 32'hCAFEF00D, 1'b1);
    rd("align_rd4", 12'h004, 1'b1, 32'hCAFEF00D);
    rd("align_rd7", 12'h007, 1'b1, 32'hCAFEF00D);
    rd("align_w0", 12'h000, 1'b1, 32'hDEAD11EF);

    wr(12'hFFC, 32'hCAFEF00D, 1'b1);
    rd("top_word", 12'hFFC, 1'b1, 32'hCAFEF00D);
    rd("top_bFFF", 12'hFFF, 1'b0, 32'h000000CA | (bext(8'hCA) & 32'hFFFF_FF00));
    rd("top_bFFC", 12'hFFC, 1'b0, 32'h0000000D);

    // read-during-write: old data before the edge, new data after
    Addr = 12'h010; DataIn = 32'h0BADF00D; MemOp = 1'b1; MemWr = 1'b1;
    #1;
    check("rdw_old", DataOut, 32'h0);
    tick();
    MemWr = 1'b0;
    model_write(12'h010, 32'h0BADF00D, 1'b1);
    #1;
    check("rdw_new", DataOut, 32'h0BADF00D);

    // random byte and word stores in 0x100-0x1FF, checked against the model
    for (int n = 0; n < 24; n++) begin
      logic [11:0] a;
      a = 12'h100 | 12'($urandom_range(0, 255));
      wr(a, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 16; n++) begin
      logic [11:0] a;
      logic        op;
      a  = 12'h100 | 12'($urandom_range(0, 255));
      op = 1'($urandom_range(0, 1));
      rd("rand_rd", a, op, model_read(a, op));
    end

    // reset wins over a simultaneous store
    rst = 1'b1; Addr = 12'h008; DataIn = 32'h55555555; MemOp = 1'b1; MemWr = 1'b1;
    #1;
    check("rst_out", DataOut, 32'h0);
    tick();
    rst = 1'b0; MemWr = 1'b0;
    for (int i = 0; i < 4096; i++) model[i] = 8'h00;
    rd("rst_rd8", 12'h008, 1'b1, 32'h0);
    rd("rst_rd0", 12'h000, 1'b1, 32'h0);
    rd("rst_rd4", 12'h004, 1'b1, 32'h0);
    rd("rst_rd10", 12'h010, 1'b1, 32'h0);
    rd("rst_rdFFC", 12'hFFC, 1'b1, 32'h0);
    for (int n = 0; n < 8; n++) begin
      logic [11:0] a;
      a = 12'h100 | 12'($urandom_range(0, 255));
      rd("rst_rand", a, 1'b1, model_read(a, 1'b1));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain got %0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
